// File: rtl/nios2_ci_core_timer_0_driver.sv
// Avalon-MM master for the interval timer register slave. It turns fabric
// commands into register sequences (start, stop, restart, snapshot) and
// services the timer irq by clearing status and emitting a tick pulse.
module nios2_ci_core_timer_0_driver #(
  parameter int TICK_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [31:0]       cmd_period,
  input  logic              cmd_cont,
  input  logic              cmd_ito,
  output logic [2:0]        av_address,
  output logic              av_chipselect,
  output logic              av_write_n,
  output logic [15:0]       av_writedata,
  input  logic [15:0]       av_readdata,
  input  logic              timer_irq,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic              snap_valid,
  output logic [31:0]       snap_value,
  output logic              busy
);

  localparam logic [1:0] OP_START   = 2'd0;
  localparam logic [1:0] OP_STOP    = 2'd1;
  localparam logic [1:0] OP_SNAP    = 2'd2;
  localparam logic [1:0] OP_RESTART = 2'd3;
  localparam logic [TICK_W-1:0] TICK_ONE = 1;

  typedef enum logic [3:0] {
    S_IDLE, S_ACK, S_PL, S_PH, S_CTRL, S_SNW, S_SRL, S_SRH, S_SCAP
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_accept;
  logic [31:0]        r_period;
  logic               r_cont;
  logic               r_ito;
  logic               r_stop;
  logic [TICK_W-1:0]  r_tick_count;
  logic [31:0]        r_snap;
  logic [31:0]        w_period;
  logic               w_cont;
  logic               w_ito;
  logic               w_stop;
  logic               w_cs;
  logic               w_wn;
  logic [2:0]         w_addr;
  logic [15:0]        w_wd;

  // Accept commands only in IDLE; a pending irq holds commands off.
  assign cmd_ready = (r_state == S_IDLE) && !timer_irq && !reset;
  assign busy      = (r_state != S_IDLE);
  assign tick      = (r_state == S_ACK);
  assign tick_count = r_tick_count;
  assign snap_valid = (r_state == S_SCAP);
  // The high half arrives on av_readdata during SCAP itself.
  assign snap_value = snap_valid ? {av_readdata, r_snap[15:0]} : r_snap;

  // Values of the command being accepted this cycle, else the stored copy,
  // so the first bus cycle of a sequence can be registered from them.
  assign w_period = (w_accept && cmd_op == OP_START) ? cmd_period : r_period;
  assign w_cont   = (w_accept && (cmd_op == OP_START || cmd_op == OP_RESTART)) ? cmd_cont : r_cont;
  assign w_ito    = (w_accept && (cmd_op == OP_START || cmd_op == OP_RESTART)) ? cmd_ito  : r_ito;
  assign w_stop   = w_accept ? (cmd_op == OP_STOP) : r_stop;

  // Next-state logic: irq service has priority over commands in IDLE.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (timer_irq) begin
          w_next = S_ACK;
        end else if (cmd_valid && cmd_ready) begin
          w_accept = 1'b1;
          case (cmd_op)
            OP_START:   w_next = S_PL;
            OP_SNAP:    w_next = S_SNW;
            default:    w_next = S_CTRL;
          endcase
        end
      end
      S_ACK:   w_next = S_IDLE;
      S_PL:    w_next = S_PH;
      S_PH:    w_next = S_CTRL;
      S_CTRL:  w_next = S_IDLE;
      S_SNW:   w_next = S_SRL;
      S_SRL:   w_next = S_SRH;
      S_SRH:   w_next = S_SCAP;
      S_SCAP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Bus cycle belonging to the state being entered; registered below.
  always_comb begin
    w_cs   = 1'b0;
    w_wn   = 1'b1;
    w_addr = 3'd0;
    w_wd   = 16'd0;
    case (w_next)
      S_ACK:  begin w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd0; end
      S_PL:   begin w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd2; w_wd = w_period[15:0]; end
      S_PH:   begin w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd3; w_wd = w_period[31:16]; end
      S_CTRL: begin
        w_cs   = 1'b1;
        w_wn   = 1'b0;
        w_addr = 3'd1;
        w_wd   = {12'd0, w_stop, !w_stop, w_cont, w_ito};
      end
      S_SNW:  begin w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd4; end
      S_SRL:  begin w_cs = 1'b1; w_addr = 3'd4; end
      S_SRH:  begin w_cs = 1'b1; w_addr = 3'd5; end
      default: ;
    endcase
  end

  // State, bus, stored command fields, tick counter and snapshot capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      av_chipselect <= 1'b0;
      av_write_n    <= 1'b1;
      av_address    <= 3'd0;
      av_writedata  <= 16'd0;
      r_cont        <= 1'b0;
      r_ito         <= 1'b0;
      r_stop        <= 1'b0;
      r_tick_count  <= '0;
      r_snap        <= 32'd0;
    end else begin
      r_state       <= w_next;
      av_chipselect <= w_cs;
      av_write_n    <= w_wn;
      av_address    <= w_addr;
      av_writedata  <= w_wd;
      r_cont        <= w_cont;
      r_ito         <= w_ito;
      r_stop        <= w_stop;
      if (w_next == S_ACK) r_tick_count <= r_tick_count + TICK_ONE;
      if (r_state == S_SRH) r_snap[15:0]  <= av_readdata;
      if (r_state == S_SCAP) r_snap[31:16] <= av_readdata;
    end
  end

  // Period is plain data: captured on START acceptance only.
  always_ff @(posedge clk) begin
    if (w_accept && cmd_op == OP_START) r_period <= cmd_period;
  end

endmodule

// File: doc/nios2_ci_core_timer_0_driver.md
Name: nios2_ci_core_timer_0_driver

Overview:
- Avalon-MM master that owns the interval timer's 16-bit register slave (3-bit address, chipselect/write_n, fixed-latency registered readdata, no waitrequest). It is the initiator end of that interface.
- Converts single-beat commands from fabric logic into register sequences: program and start, stop, restart, and snapshot read.
- Services the timer irq by clearing status and issuing a tick pulse, so fabric logic gets periodic events without a CPU.

Parameters:
TICK_W, 16, width of the wrapping tick counter.

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_op  in  2  0=START, 1=STOP, 2=SNAP, 3=RESTART
cmd_period  in  32  period value for START
cmd_cont  in  1  continuous mode for START/RESTART
cmd_ito  in  1  interrupt enable for START/RESTART
av_address  out  3  timer register address
av_chipselect  out  1  bus select
av_write_n  out  1  active-low write
av_writedata  out  16  write data
av_readdata  in  16  timer read data, registered in the slave
timer_irq  in  1  timer interrupt
tick  out  1  one-cycle pulse per serviced irq
tick_count  out  TICK_W  serviced-irq count, wraps
snap_valid  out  1  one-cycle pulse, snap_value valid
snap_value  out  32  captured counter snapshot
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: cmd_ready=0, av_chipselect=0, av_write_n=1, av_address=0, av_writedata=0, tick=0, tick_count=0, snap_valid=0, snap_value=0, busy=0. Stored cont_q/ito_q reset to 0. State goes to IDLE.
- All av_* outputs are registered. Each state drives exactly one bus cycle of one clock. Idle bus: chipselect=0, write_n=1, address=0, writedata=0.
- Read timing: the slave registers readdata from the address on every clock. Data for an address driven in cycle N is captured from av_readdata in cycle N+1.
- Register map driven: 0 status (any write clears timeout), 1 control {stop[3], start[2], cont[1], ito[0]}, 2 period_l, 3 period_h, 4/5 snap_l/snap_h (any write latches snapshot; reads return it).
- States:
  - IDLE: cmd_ready=1 unless timer_irq=1.
  - ACK: write addr0, data 0. In the same cycle pulse tick and increment tick_count. Next state is IDLE.
  - PL: write addr2 = period[15:0]. Next PH.
  - PH: write addr3 = period[31:16]. Next CTRL.
  - CTRL: write addr1 = {stop, start, cont_q, ito_q}. Next IDLE.
  - SNW: write addr4, data 0. Next SRL.
  - SRL: read addr4. Next SRH.
  - SRH: read addr5, capture snap_value[15:0]. Next SCAP.
  - SCAP: bus idle, capture snap_value[31:16], pulse snap_valid. Next IDLE.
- IDLE transitions:
  - timer_irq=1 goes to ACK and takes priority: cmd_ready=0 that cycle, command is held off.
  - START latches period, cont_q, ito_q and goes to PL. CTRL then writes start=1, stop=0.
  - RESTART latches cont_q, ito_q and goes straight to CTRL with start=1.
  - STOP goes to CTRL with stop=1, start=0, cont_q/ito_q unchanged.
  - SNAP goes to SNW.
- Command latency in bus cycles: START 3, RESTART/STOP 1, SNAP 4 (snap_valid in the 4th cycle after acceptance).
- cmd_period=0 is passed through unchanged; the timer then fires every cycle, and the tick rate is bounded by one ACK per 2 cycles.
- timer_irq is ignored outside IDLE and serviced on return to IDLE. Irqs that occur while one is pending collapse into one tick, matching the slave's single timeout flag.
- tick_count wraps from 2^TICK_W-1 to 0.
- Reset asserted mid-sequence aborts it immediately. Bus goes idle next edge, with no partial write repeated. The timer keeps whatever registers were already written.

Test Plan:
- START period=0x0001_86A0, cont=1, ito=1 -> bus writes in consecutive cycles: addr2=0x86A0, addr3=0x0001, addr1=0x0007. busy high for 3 cycles, cmd_ready low until IDLE.
- timer_irq held high until status write -> ACK writes addr0 exactly once, one tick pulse, tick_count 0->1, irq observed low the cycle after.
- SNAP with av_readdata model returning 0x1234 (addr4), 0x0056 (addr5) -> write addr4, then reads; snap_value=0x0056_1234, snap_valid for one cycle, 4 cycles after acceptance.
- cmd_valid STOP and timer_irq rise the same IDLE cycle -> ACK first (cmd_ready=0), then STOP accepted, writing addr1=0x000B (cont=1, ito=1 retained).
- tick_count preloaded to 0xFFFF by 65535 irqs, one more irq -> tick_count=0x0000.
- reset asserted during PH of a START -> next cycle chipselect=0, write_n=1, all outputs at reset values, no addr1 write follows.
